lcd_bus_receiver: RTL and testbench
===================================

// Module: lcd_bus_receiver
// PURPOSE
//  Receiving end of the 8-bit 8080-style LCD write bus (lcd_db/lcd_wr/lcd_d_c/lcd_rd/lcd_reset)
//  that the screen controller drives. Decodes the command/parameter stream: CASET 0x2A,
//  PASET 0x2B, RAMWR 0x2C, SWRESET 0x01. Emits one pixel per RGB565 pair with its screen
//  coordinate. Used as panel model in sim and as on-board bus monitor.
// PARAMETERS
//  H_RES        320  panel width; default column window 0..H_RES-1, pixels with x>=H_RES dropped
//  V_RES        240  panel height; default page window 0..V_RES-1, pixels with y>=V_RES dropped
//  SYNC_STAGES  2    flops on each bus input before decode (>=2)
// PORTS
//  clk         in   1   single system clock, all logic on rising edge
//  resetN      in   1   asynchronous, active-low reset
//  lcd_db      in   8   bus data byte
//  lcd_wr      in   1   write strobe, active-low; byte latched on its rising edge
//  lcd_d_c     in   1   0 = command byte, 1 = parameter/data byte
//  lcd_rd      in   1   read strobe; ignored (reads unsupported)
//  lcd_reset   in   1   panel hardware reset, active-low
//  cmd_valid   out  1   1-cycle pulse per command byte
//  cmd_code    out  8   last command byte, held
//  frame_start out  1   1-cycle pulse on each RAMWR command
//  pix_valid   out  1   1-cycle pulse per in-range pixel
//  pix_x       out  $clog2(H_RES)  pixel column, held
//  pix_y       out  $clog2(V_RES)  pixel row, held
//  pix_rgb     out  16  RGB565 {first byte, second byte}, held
// BEHAVIOUR
//  - resetN=0: all outputs 0 immediately. State IDLE, window = defaults, cur_x=cur_y=0.
//  - lcd_db, lcd_wr, lcd_d_c, lcd_reset pass through SYNC_STAGES flops. Strobe = synced lcd_wr
//    is 1 and was 0 the previous cycle (cycle N). db and d_c sampled at that same synced point.
//    All outputs update at cycle N+1 (1-cycle registered latency after detection).
//  - Transmitter holds db/d_c stable >= SYNC_STAGES+1 clk after the WR rising edge. WR low and
//    high each last >= 2 clk.
//  - Command byte (d_c=0): cmd_valid=1, cmd_code=byte. Aborts any state, and any pending RAMWR
//    high byte is discarded.
//    0x2A -> CASET(idx 0), 0x2B -> PASET(idx 0), 0x2C -> RAMWR_HI (also frame_start=1,
//    cur_x=SC, cur_y=SP), 0x01 -> window = defaults then IDLE, anything else -> IGNORE.
//  - CASET/PASET: 4 params, MSB first: start[15:8], start[7:0], end[15:8], end[7:0].
//    Buffered, and SC/EC (SP/EP) written atomically on the 4th param. Then state IGNORE.
//    If a command arrives before the 4th param, the old window is kept.
//  - RAMWR_HI: store byte as hi -> RAMWR_LO. RAMWR_LO: pixel = {hi, byte} -> RAMWR_HI.
//    pix_valid=1 only if cur_x<H_RES and cur_y<V_RES, with pix_x/pix_y = cur_x/cur_y truncated.
//    Counters advance whether or not the pixel is dropped.
//    Advance rule: if cur_x==EC, cur_x=SC and (cur_y==EP ? cur_y=SP : cur_y+1);
//    else cur_x+1. Counters are 16 bit and wrap modulo 2^16 when SC>EC.
//  - IDLE/IGNORE: data bytes discarded, no output.
//  - Synced lcd_reset=0: same effect as SWRESET, and state IDLE. Strobes ignored while low.
//    cmd_code/pix_* hold their values.
//  - lcd_rd has no effect. Strobe edges closer together than allowed are undefined.
// TESTING
//  1 resetN pulse, cmd 2C, data F8,00 -> frame_start; pix_valid once, x=0 y=0 rgb=F800.
//  2 CASET 00,0A,00,0C; PASET 00,05,00,06; 2C; 8 pixel pairs -> coords (10,5)(11,5)(12,5)
//    (10,6)(11,6)(12,6)(10,5)(11,5), i.e. column and page wrap.
//  3 CASET 01,3E,01,41; 2C; 4 pixels -> x=318,319 valid; 320,321 no pix_valid.
//  4 2C; data 12; cmd 00 -> no pix_valid, cmd_valid with code 00. Next data 34,56 -> none (IGNORE).
//  5 CASET 00,05 only; 2C; 1 pixel -> pixel at x=0 (window unchanged).
//    Then lcd_reset low mid-RAMWR; 2C; pixel -> (0,0).
//  6 resetN low between the two bytes of a pixel -> outputs 0 same cycle.
//    After release, a data byte produces no pixel.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// Receiving end of an 8-bit 8080-style LCD write bus: synchronises the bus, decodes
// CASET/PASET/RAMWR/SWRESET and emits RGB565 pixels with their screen coordinates.
module lcd_bus_receiver #(
  parameter  int H_RES       = 320,
  parameter  int V_RES       = 240,
  parameter  int SYNC_STAGES = 2,
  localparam int XW          = $clog2(H_RES),
  localparam int YW          = $clog2(V_RES)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic [7:0]    lcd_db,
  input  logic          lcd_wr,
  input  logic          lcd_d_c,
  input  logic          lcd_rd,
  input  logic          lcd_reset,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic          frame_start,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [15:0]   pix_rgb
);

  localparam logic [15:0] L_H_RES  = 16'(H_RES);
  localparam logic [15:0] L_V_RES  = 16'(V_RES);
  localparam logic [15:0] L_EC_DEF = 16'(H_RES - 1);
  localparam logic [15:0] L_EP_DEF = 16'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_IGNORE, S_CASET, S_PASET, S_RAMWR_HI, S_RAMWR_LO
  } state_t;

  logic [SYNC_STAGES-1:0] r_wr_sync, r_dc_sync, r_rst_sync;
  logic [7:0]             r_db_sync [SYNC_STAGES];
  logic                   r_wr_prev;
  logic                   w_wr_s, w_dc_s, w_rst_s, w_strobe;
  logic [7:0]             w_db_s;
  logic                   w_unused;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [23:0] r_par;
  logic [7:0]  r_hi;
  logic [15:0] r_sc, r_ec, r_sp, r_ep;
  logic [15:0] r_cur_x, r_cur_y;

  assign w_unused = lcd_rd;

  // The write strobe chain resets high so an idle bus never looks like a rising edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_sync  <= '1;
      r_dc_sync  <= '0;
      r_rst_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_db_sync[i] <= '0;
    end else begin
      r_wr_sync    <= {r_wr_sync[SYNC_STAGES-2:0], lcd_wr};
      r_dc_sync    <= {r_dc_sync[SYNC_STAGES-2:0], lcd_d_c};
      r_rst_sync   <= {r_rst_sync[SYNC_STAGES-2:0], lcd_reset};
      r_db_sync[0] <= lcd_db;
      for (int i = 1; i < SYNC_STAGES; i++) r_db_sync[i] <= r_db_sync[i-1];
    end
  end

  assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
  assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];
  assign w_rst_s  = r_rst_sync[SYNC_STAGES-1];
  assign w_db_s   = r_db_sync[SYNC_STAGES-1];
  assign w_strobe = w_wr_s & ~r_wr_prev;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_prev   <= 1'b1;
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_par       <= '0;
      r_hi        <= '0;
      r_sc        <= '0;
      r_ec        <= L_EC_DEF;
      r_sp        <= '0;
      r_ep        <= L_EP_DEF;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      r_wr_prev   <= w_wr_s;
      cmd_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      if (!w_rst_s) begin
        r_state <= S_IDLE;
        r_sc    <= '0;
        r_ec    <= L_EC_DEF;
        r_sp    <= '0;
        r_ep    <= L_EP_DEF;
      end else if (w_strobe && !w_dc_s) begin
        cmd_valid <= 1'b1;
        cmd_code  <= w_db_s;
        r_idx     <= '0;
        case (w_db_s)
          8'h2A: r_state <= S_CASET;
          8'h2B: r_state <= S_PASET;
          8'h2C: begin
            r_state     <= S_RAMWR_HI;
            frame_start <= 1'b1;
            r_cur_x     <= r_sc;
            r_cur_y     <= r_sp;
          end
          8'h01: begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_ec    <= L_EC_DEF;
            r_sp    <= '0;
            r_ep    <= L_EP_DEF;
          end
          default: r_state <= S_IGNORE;
        endcase
      end else if (w_strobe) begin
        case (r_state)
          S_CASET, S_PASET: begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_par[23:16] <= w_db_s;
              2'd1: r_par[15:8]  <= w_db_s;
              2'd2: r_par[7:0]   <= w_db_s;
              default: begin
                // Window registers change only once all four parameters have arrived.
                if (r_state == S_CASET) begin
                  r_sc <= r_par[23:8];
                  r_ec <= {r_par[7:0], w_db_s};
                end else begin
                  r_sp <= r_par[23:8];
                  r_ep <= {r_par[7:0], w_db_s};
                end
                r_state <= S_IGNORE;
              end
            endcase
          end
          S_RAMWR_HI: begin
            r_hi    <= w_db_s;
            r_state <= S_RAMWR_LO;
          end
          S_RAMWR_LO: begin
            r_state <= S_RAMWR_HI;
            if ((r_cur_x < L_H_RES) && (r_cur_y < L_V_RES)) begin
              pix_valid <= 1'b1;
              pix_x     <= r_cur_x[XW-1:0];
              pix_y     <= r_cur_y[YW-1:0];
              pix_rgb   <= {r_hi, w_db_s};
            end
            // Address advance runs even for dropped pixels, wrapping inside the window.
            if (r_cur_x == r_ec) begin
              r_cur_x <= r_sc;
              r_cur_y <= (r_cur_y == r_ep) ? r_sp : r_cur_y + 16'd1;
            end else begin
              r_cur_x <= r_cur_x + 16'd1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives 8080 write cycles and checks decoded
// commands and pixels against hand-computed tables and sequences.
module tb_lcd_bus_receiver;
  localparam int H_RES = 320;
  localparam int V_RES = 240;
  localparam int XW    = $clog2(H_RES);
  localparam int YW    = $clog2(V_RES);

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [7:0]    lcd_db = 8'h00;
  logic          lcd_wr = 1'b1;
  logic          lcd_d_c = 1'b0;
  logic          lcd_rd = 1'b1;
  logic          lcd_reset = 1'b1;
  logic          cmd_valid;
  logic [7:0]    cmd_code;
  logic          frame_start;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [15:0]   pix_rgb;

  lcd_bus_receiver #(.H_RES(H_RES), .V_RES(V_RES), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetN(resetN), .lcd_db(lcd_db), .lcd_wr(lcd_wr), .lcd_d_c(lcd_d_c),
    .lcd_rd(lcd_rd), .lcd_reset(lcd_reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pix_cnt = 0;
  int          cmd_cnt = 0;
  int          fs_cnt = 0;
  logic [XW-1:0] last_x = '0;
  logic [YW-1:0] last_y = '0;
  logic [15:0] last_rgb = '0;
  logic [7:0]  last_cmd = '0;

  always @(negedge clk) begin
    if (pix_valid) begin
      pix_cnt++;
      last_x   = pix_x;
      last_y   = pix_y;
      last_rgb = pix_rgb;
    end
    if (cmd_valid) begin
      cmd_cnt++;
      last_cmd = cmd_code;
    end
    if (frame_start) fs_cnt++;
  end

  typedef struct {
    logic [7:0]    hi;
    logic [7:0]    lo;
    logic          exp_v;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pvec_t;

  pvec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic dc, input logic [7:0] b);
    @(posedge clk); #1;
    lcd_d_c = dc;
    lcd_db  = b;
    lcd_wr  = 1'b0;
    repeat (3) @(posedge clk);
    #1 lcd_wr = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] b);
    bus_wr(1'b0, b);
  endtask

  task automatic dat(input logic [7:0] b);
    bus_wr(1'b1, b);
  endtask

  task automatic apply_vec(input int i);
    int c0;
    c0 = pix_cnt;
    dat(tbl[i].hi);
    dat(tbl[i].lo);
    chk($sformatf("vec%0d_cnt", i), 32'(pix_cnt - c0), 32'(tbl[i].exp_v));
    if (tbl[i].exp_v) begin
      chk($sformatf("vec%0d_x", i), 32'(last_x), 32'(tbl[i].x));
      chk($sformatf("vec%0d_y", i), 32'(last_y), 32'(tbl[i].y));
      chk($sformatf("vec%0d_rgb", i), 32'(last_rgb), 32'({tbl[i].hi, tbl[i].lo}));
    end
  endtask

  initial begin
    int c0, k0, f0;
    int xs [8] = '{10, 11, 12, 10, 11, 12, 10, 11};
    int ys [8] = '{5, 5, 5, 6, 6, 6, 5, 5};
    for (int i = 0; i < 8; i++) begin
      tbl[i].hi = 8'h10 + 8'(i);
      tbl[i].lo = 8'h80 + 8'(i);
      tbl[i].exp_v = 1'b1;
      tbl[i].x = XW'(xs[i]);
      tbl[i].y = YW'(ys[i]);
    end
    for (int i = 8; i < 12; i++) begin
      tbl[i].hi = 8'hC0 + 8'(i);
      tbl[i].lo = 8'h3C - 8'(i);
      tbl[i].exp_v = (i < 10);
      tbl[i].x = XW'(318 + i - 8);
      tbl[i].y = YW'(5);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_code", 32'(cmd_code), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    chk("rst_pix_y", 32'(pix_y), 0);
    chk("rst_pix_rgb", 32'(pix_rgb), 0);
    resetN = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 1: single pixel at the default window origin
    k0 = cmd_cnt; f0 = fs_cnt; c0 = pix_cnt;
    cmd(8'h2C);
    chk("t1_cmd_cnt", 32'(cmd_cnt - k0), 1);
    chk("t1_cmd_code", 32'(last_cmd), 32'h2C);
    chk("t1_frame_start", 32'(fs_cnt - f0), 1);
    dat(8'hF8);
    chk("t1_no_pix_hi", 32'(pix_cnt - c0), 0);
    dat(8'h00);
    chk("t1_pix_cnt", 32'(pix_cnt - c0), 1);
    chk("t1_x", 32'(last_x), 0);
    chk("t1_y", 32'(last_y), 0);
    chk("t1_rgb", 32'(last_rgb), 32'hF800);

    // 2: 3x2 window, column and page wrap
    cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    f0 = fs_cnt;
    cmd(8'h2C);
    chk("t2_frame_start", 32'(fs_cnt - f0), 1);
    for (int i = 0; i < 8; i++) apply_vec(i);

    // 3: window straddling the right edge, out-of-range pixels dropped
    cmd(8'h2A); dat(8'h01); dat(8'h3E); dat(8'h01); dat(8'h41);
    cmd(8'h2C);
    for (int i = 8; i < 12; i++) apply_vec(i);

    // 4: unknown command aborts a half-received pixel
    cmd(8'h2C);
    c0 = pix_cnt; k0 = cmd_cnt;
    dat(8'h12);
    cmd(8'h00);
    chk("t4_cmd_cnt", 32'(cmd_cnt - k0), 1);
    chk("t4_cmd_code", 32'(last_cmd), 32'h00);
    dat(8'h34);
    dat(8'h56);
    chk("t4_no_pix", 32'(pix_cnt - c0), 0);

    // 5: SWRESET to defaults, truncated CASET keeps the old window
    cmd(8'h01);
    chk("t5_swreset_code", 32'(cmd_code), 32'h01);
    cmd(8'h2A); dat(8'h00); dat(8'h05);
    cmd(8'h2C);
    c0 = pix_cnt;
    dat(8'hAB); dat(8'hCD);
    chk("t5_pix_cnt", 32'(pix_cnt - c0), 1);
    chk("t5_x", 32'(last_x), 0);
    chk("t5_y", 32'(last_y), 0);
    chk("t5_rgb", 32'(last_rgb), 32'hABCD);

    // 5b: panel reset line low in the middle of a pixel
    cmd(8'h2A); dat(8'h00); dat(8'h07); dat(8'h00); dat(8'h09);
    cmd(8'h2B); dat(8'h00); dat(8'h03); dat(8'h00); dat(8'h04);
    cmd(8'h2C);
    c0 = pix_cnt;
    dat(8'h5A);
    lcd_reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dat(8'h11);
    chk("t5b_ignored_low", 32'(pix_cnt - c0), 0);
    chk("t5b_cmd_held", 32'(cmd_code), 32'h2C);
    chk("t5b_rgb_held", 32'(pix_rgb), 32'hABCD);
    lcd_reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cmd(8'h2C);
    dat(8'hCD); dat(8'hEF);
    chk("t5b_pix_cnt", 32'(pix_cnt - c0), 1);
    chk("t5b_x", 32'(last_x), 0);
    chk("t5b_y", 32'(last_y), 0);
    chk("t5b_rgb", 32'(last_rgb), 32'hCDEF);

    // 6: asynchronous reset between the two bytes of a pixel
    cmd(8'h2C);
    dat(8'h77);
    @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    chk("t6_cmd_code", 32'(cmd_code), 0);
    chk("t6_pix_x", 32'(pix_x), 0);
    chk("t6_pix_rgb", 32'(pix_rgb), 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    c0 = pix_cnt;
    dat(8'h88);
    dat(8'h99);
    chk("t6_no_pix", 32'(pix_cnt - c0), 0);
    chk("t6_rgb_zero", 32'(pix_rgb), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
